// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, drives a combinational instruction memory and
// buffers {pc, instr} pairs in a small FIFO so decode can stall independently.
module fetch_queue #(
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter int unsigned          DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_WIDTH-1:0]      imem_addr,
  input  logic [INSTR_WIDTH-1:0]     imem_instr,
  input  logic                       redirect_en,
  input  logic [ADDR_WIDTH-1:0]      redirect_pc,
  input  logic                       stall,
  output logic                       id_valid,
  output logic [INSTR_WIDTH-1:0]     id_instr,
  output logic [ADDR_WIDTH-1:0]      id_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       FULL_CNT = CNT_W'(DEPTH);
  localparam logic [INSTR_WIDTH-1:0] NOP      = INSTR_WIDTH'(32'h0000_0013);

  logic [ADDR_WIDTH-1:0]  r_fpc;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [ADDR_WIDTH-1:0]  r_pc_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] r_instr_q [DEPTH];

  logic                   w_valid;
  logic                   w_pop;
  logic                   w_push;
  logic [ADDR_WIDTH-1:0]  w_redirect_tgt;

  assign w_valid        = (r_count != '0);
  assign w_pop          = w_valid & ~stall & ~redirect_en;
  assign w_push         = ~redirect_en & ((r_count != FULL_CNT) | w_pop);
  // Word-align the target by masking rather than slicing, so every input bit is consumed.
  assign w_redirect_tgt = redirect_pc & ~ADDR_WIDTH'(3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fpc    <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_en) begin
      r_fpc    <= w_redirect_tgt;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fpc    <= r_fpc + ADDR_WIDTH'(4);
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_pc_q[r_wr_ptr]    <= r_fpc;
      r_instr_q[r_wr_ptr] <= imem_instr;
    end
  end

  assign imem_addr = r_fpc;
  assign count     = r_count;
  assign id_valid  = w_valid;
  assign id_instr  = w_valid ? r_instr_q[r_rd_ptr] : NOP;
  assign id_pc     = w_valid ? r_pc_q[r_rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; the instruction memory returns 0x100 + address.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [2:0]  count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  fetch_queue #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .DEPTH      (4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .count      (count)
  );

  always #5 clk = ~clk;

  assign imem_instr = 32'h100 + imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] cnt,
                           input logic [31:0] addr);
    check({tag, ".valid"}, {31'b0, id_valid}, {31'b0, v});
    check({tag, ".instr"}, id_instr, instr);
    check({tag, ".pc"}, id_pc, pc);
    check({tag, ".count"}, {29'b0, count}, cnt);
    check({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;

    // Reset state
    tick(); tick();
    check_all("reset", 1'b0, 32'h13, 32'h0, 0, 32'h0);

    // Streaming, stall=0: one entry per cycle, count stays 1
    reset = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      check_all($sformatf("stream%0d", k), 1'b1, 32'h100 + 4*k, 4*k, 1, 4*(k+1));
    end

    // Stall from reset release: fill to DEPTH, fpc freezes at 0x10
    reset = 1'b0; tick();
    reset = 1'b1; stall = 1'b1;
    for (int unsigned k = 1; k <= 6; k++) begin
      tick();
      check_all($sformatf("fill%0d", k), 1'b1, 32'h100, 32'h0,
                (k < 4) ? k : 4, (k < 4) ? 4*k : 32'h10);
    end

    // Release while full: pop+push every edge, order preserved across wraps
    stall = 1'b0;
    for (int unsigned k = 1; k <= 14; k++) begin
      tick();
      check_all($sformatf("drain%0d", k), 1'b1, 32'h100 + 4*k, 4*k, 4, 32'h10 + 4*k);
    end

    // Build 3 entries, then redirect to 0x203
    reset = 1'b0; tick();
    reset = 1'b1; stall = 1'b1;
    tick(); tick(); tick();
    check_all("pre_redir", 1'b1, 32'h100, 32'h0, 3, 32'hC);
    stall = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h203;
    tick();
    check_all("redir_n1", 1'b0, 32'h13, 32'h0, 0, 32'h200);
    redirect_en = 1'b0;
    tick();
    check_all("redir_n2", 1'b1, 32'h300, 32'h200, 1, 32'h204);

    // Redirect together with stall: redirect wins
    stall = 1'b1;
    tick(); tick();
    check_all("pre_redir_st", 1'b1, 32'h300, 32'h200, 3, 32'h20C);
    redirect_en = 1'b1; redirect_pc = 32'h403;
    tick();
    check_all("redir_st_n1", 1'b0, 32'h13, 32'h0, 0, 32'h400);
    redirect_en = 1'b0;
    tick();
    check_all("redir_st_n2", 1'b1, 32'h500, 32'h400, 1, 32'h404);

    // Reset mid-stream with stall and redirect asserted
    tick(); tick();
    check_all("pre_rst", 1'b1, 32'h500, 32'h400, 3, 32'h40C);
    reset = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h800;
    tick();
    check_all("rst_mid", 1'b0, 32'h13, 32'h0, 0, 32'h0);
    reset = 1'b1; redirect_en = 1'b0; stall = 1'b0;
    tick();
    check_all("rst_rel", 1'b1, 32'h100, 32'h0, 1, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage with a small prefetch FIFO, sitting directly upstream of the decode stage. It owns the fetch PC, drives the combinational instruction memory, and buffers fetched {pc, instr} pairs so decode can stall on hazards while fetch keeps running. On a taken branch or jump from decode, it discards all buffered entries and restarts fetch at the target address.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC and instruction-memory address width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clk
- imem_addr  out  ADDR_WIDTH  fetch address to instruction memory; equals the fetch PC
- imem_instr  in  INSTR_WIDTH  instruction at imem_addr, valid in the same cycle (combinational memory)
- redirect_en  in  1  decode requests a PC change (branch/jump taken)
- redirect_pc  in  ADDR_WIDTH  target address; bits [1:0] are ignored and treated as 0
- stall  in  1  decode hazard; head entry must not be consumed
- id_valid  out  1  head entry present
- id_instr  out  INSTR_WIDTH  head instruction; 32'h0000_0013 (NOP) when id_valid=0
- id_pc  out  ADDR_WIDTH  head PC; 0 when id_valid=0
- count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State: fetch PC register `fpc`, DEPTH-entry storage of {pc, instr}, read and write pointers that wrap modulo DEPTH, and an occupancy counter.
- `imem_addr = fpc` (combinational).
- pop = id_valid & ~stall & ~redirect_en.
- push = ~redirect_en & ((count < DEPTH) | pop).
- On push: write {fpc, imem_instr} at the write pointer, advance the write pointer, and set fpc <= fpc + 4. The add wraps modulo 2^ADDR_WIDTH.
- No push: fpc holds.
- Pop: advance the read pointer.
- count update: count <= count + push - pop.
- Push and pop in the same cycle while full: both occur and count stays at DEPTH.
- Push and pop in the same cycle while count=1: both occur and count stays at 1.
- Redirect (priority over everything, including stall):
  - pointers and count are cleared;
  - fpc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  - imem_instr is discarded that cycle;
  - the entry on id_* that cycle is not consumed; it is flushed.
- Empty with stall=1: nothing is popped; push continues.
- id_* are driven from the head storage entry, gated by id_valid = (count != 0). They change only on clock edges.
- Reset (reset=0 at posedge), regardless of any other input:
  - fpc=RESET_PC, pointers=0, count=0;
  - id_valid=0, id_instr=NOP, id_pc=0, imem_addr=RESET_PC.

## Timing
- Fetch-to-decode latency is 1 cycle. The instruction fetched in cycle N appears on id_* in cycle N+1 if the queue was empty.
- Sustained throughput is 1 instruction/cycle when stall=0.
- Redirect asserted in cycle N:
  - cycle N+1: id_valid=0, count=0, imem_addr=target;
  - cycle N+2: id_valid=1, id_pc=target.
  - Redirect penalty: 1 bubble cycle.
- With stall held high from an empty queue, count reaches DEPTH after DEPTH cycles. fpc then freezes at start + 4·DEPTH.
- Stall released while full: a pop and a push happen on the same edge, so there is no bubble.
- Releasing reset in cycle N means cycle N fetches RESET_PC; id_valid rises in cycle N+1.
- Reset asserted mid-stream (queue non-empty, stall=1, redirect_en=1 simultaneously) takes effect at the next edge. All outputs return to their reset values.

## Test plan
- Reset release, stall=0, memory returns instr = 0x100 + addr → id_pc sequence 0, 4, 8, …, one per cycle starting one cycle after release; id_instr = 0x100, 0x104, …; count stays 1.
- stall=1 for 6 cycles from reset release → count goes 1, 2, 3, 4, 4, 4; imem_addr freezes at 0x10; id_pc stays 0. Release stall → id_pc 4, 8, 0xC, 0x10 with no bubble.
- Queue holding 3 entries, redirect_en=1 with redirect_pc=0x203 → next cycle id_valid=0, count=0, imem_addr=0x200; the following cycle id_pc=0x200.
- redirect_en=1 and stall=1 in the same cycle → redirect wins; same response as the previous case.
- Full queue with pop in the same cycle (stall=0) → count stays 4; the pushed entry is the next fpc; order is preserved across pointer wrap (run ≥ 3·DEPTH entries).
- reset=0 asserted while count=3 and mid-redirect → next cycle count=0, id_valid=0, id_instr=0x13, imem_addr=RESET_PC.
